// File: rtl/pipelined_lane_pkg.sv
// Shared types and default sizing for the pipelined execution lane.
// The opcode set covers the integer and floating-point functions the lane decodes.
package pipelined_lane_pkg;

    localparam int DEFAULT_DATA_W   = 64;
    localparam int DEFAULT_NUM_VREG = 32;

    typedef enum logic [2:0] {
        SADD = 3'd0,
        SSUB = 3'd1,
        SMUL = 3'd2,
        SDIV = 3'd3,
        FADD = 3'd4,
        FSUB = 3'd5,
        FMUL = 3'd6,
        FDIV = 3'd7
    } function_opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        HOLD = 2'd2
    } lane_state_t;

endpackage

// File: rtl/lane_divider.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle.
// done pulses with the final quotient presented combinationally on quotient.
module lane_divider
    import pipelined_lane_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              active_q;

    logic [DATA_W:0]   shifted;
    logic              ge;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;

    // Remainder stays below the divisor, so the restored value always fits DATA_W bits.
    always_comb begin
        shifted  = {rem_q, quo_q[DATA_W-1]};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_next = ge ? DATA_W'(shifted - {1'b0, dvs_q}) : shifted[DATA_W-1:0];
        quo_next = {quo_q[DATA_W-2:0], ge};
    end

    assign done     = active_q && (cnt_q == CNT_W'(1));
    assign quotient = quo_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            rem_q    <= '0;
            quo_q    <= dividend;
            dvs_q    <= divisor;
            cnt_q    <= CNT_W'(DATA_W);
            active_q <= 1'b1;
        end else if (active_q) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipelined_lane.sv
// Single execution lane: one-cycle add/sub/mul, iterative divide, and a result
// holding register that stalls intake until writeback consumes it.
module pipelined_lane
    import pipelined_lane_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_VREG = DEFAULT_NUM_VREG,
    localparam int VREG_W  = $clog2(NUM_VREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [VREG_W-1:0] in_vreg,
    input  function_opcode_t in_opcode,
    output logic             out_vld,
    output logic [VREG_W-1:0] out_vreg,
    output logic [DATA_W-1:0] out_data,
    output logic             out_err,
    input  logic             wb_rdy,
    output logic             busy
);

    lane_state_t       state;
    lane_state_t       state_next;
    logic              accept;
    logic              div_start;
    logic              div_done;
    logic [DATA_W-1:0] div_quotient;

    // Single-cycle result as {err, data}; unsupported opcodes report an error with zero data.
    function automatic logic [DATA_W:0] alu_eval(
        input function_opcode_t  op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        case (op)
            SADD:    return {1'b0, a + b};
            SSUB:    return {1'b0, a - b};
            SMUL:    return {1'b0, a * b};
            SDIV:    return {1'b1, {DATA_W{1'b1}}};
            default: return {1'b1, {DATA_W{1'b0}}};
        endcase
    endfunction

    assign in_rdy    = (state == IDLE) || ((state == HOLD) && wb_rdy);
    assign busy      = !in_rdy;
    assign accept    = in_vld && in_rdy;
    assign div_start = accept && (in_opcode == SDIV) && (in_data1 != '0);

    lane_divider #(
        .DATA_W (DATA_W)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (in_data0),
        .divisor  (in_data1),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    state_next = div_start ? DIV : HOLD;
                end else if ((state == HOLD) && wb_rdy) begin
                    state_next = IDLE;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_next = HOLD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new acceptance in HOLD overwrites the result being consumed the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            out_vld  <= 1'b0;
            out_vreg <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                out_vreg <= in_vreg;
                if (div_start) begin
                    out_vld <= 1'b0;
                end else begin
                    out_vld             <= 1'b1;
                    {out_err, out_data} <= alu_eval(in_opcode, in_data0, in_data1);
                end
            end else if (div_done) begin
                out_vld  <= 1'b1;
                out_data <= div_quotient;
                out_err  <= 1'b0;
            end else if (out_vld && wb_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_lane.sv
// Bench for pipelined_lane: directed scenarios plus a randomized run against a
// cycle-level transaction model of the lane.
module tb_pipelined_lane;
    import pipelined_lane_pkg::*;

    localparam int DATA_W   = 64;
    localparam int NUM_VREG = 32;
    localparam int VREG_W   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_vld;
    logic              in_rdy;
    logic [DATA_W-1:0] in_data0;
    logic [DATA_W-1:0] in_data1;
    logic [VREG_W-1:0] in_vreg;
    function_opcode_t  in_opcode;
    logic              out_vld;
    logic [VREG_W-1:0] out_vreg;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              wb_rdy;
    logic              busy;

    int checks = 0;
    int errors = 0;

    pipelined_lane #(
        .DATA_W   (DATA_W),
        .NUM_VREG (NUM_VREG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_vreg   (in_vreg),
        .in_opcode (in_opcode),
        .out_vld   (out_vld),
        .out_vreg  (out_vreg),
        .out_data  (out_data),
        .out_err   (out_err),
        .wb_rdy    (wb_rdy),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expected {err, data} from the arithmetic definition of each opcode.
    function automatic logic [DATA_W:0] ref_op(input function_opcode_t op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (op)
            SADD: begin r = a + b; return {1'b0, r}; end
            SSUB: begin r = a - b; return {1'b0, r}; end
            SMUL: begin r = a * b; return {1'b0, r}; end
            SDIV: begin
                if (b == 0) return {1'b1, {DATA_W{1'b1}}};
                r = a / b;
                return {1'b0, r};
            end
            default: return {1'b1, {DATA_W{1'b0}}};
        endcase
    endfunction

    task automatic drive_op(input function_opcode_t op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input logic [VREG_W-1:0] tag);
        in_vld    = 1'b1;
        in_opcode = op;
        in_data0  = a;
        in_data1  = b;
        in_vreg   = tag;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_vld   = 1'b0;
        in_data0 = '0;
        in_data1 = '0;
        in_vreg  = '0;
        in_opcode = SADD;
        wb_rdy   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
        checks++; if (out_vreg !== '0) begin errors++; $display("FAIL reset_out_vreg got %0d want 0", out_vreg); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_add_wrap();
        wb_rdy = 1'b1;
        drive_op(SADD, {DATA_W{1'b1}}, 64'd1, 5'd5);
        settle();
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL add_in_rdy got %b want 1", in_rdy); end
        tick();
        in_vld = 1'b0;
        settle();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL add_out_vld got %b want 1", out_vld); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL add_wrap_data got %h want 0", out_data); end
        checks++; if (out_vreg !== 5'd5) begin errors++; $display("FAIL add_vreg got %0d want 5", out_vreg); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL add_err got %b want 0", out_err); end
        tick();
        settle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL add_consumed got %b want 0", out_vld); end
    endtask

    task automatic test_div();
        int n;
        int low;
        wb_rdy = 1'b1;
        drive_op(SDIV, 64'd100, 64'd7, 5'd9);
        settle();
        tick();
        in_vld = 1'b0;
        settle();
        n   = 0;
        low = 0;
        while (out_vld !== 1'b1 && n < 200) begin
            if (in_rdy === 1'b0) low++;
            tick();
            settle();
            n++;
        end
        checks++; if (n !== 64) begin errors++; $display("FAIL div_latency got %0d want 64 cycles before result", n); end
        checks++; if (low !== 64) begin errors++; $display("FAIL div_in_rdy_low got %0d want 64", low); end
        checks++; if (out_data !== 64'd14) begin errors++; $display("FAIL div_quotient got %0d want 14", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL div_err got %b want 0", out_err); end
        checks++; if (out_vreg !== 5'd9) begin errors++; $display("FAIL div_vreg got %0d want 9", out_vreg); end
        tick();
        settle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL div_consumed got %b want 0", out_vld); end
    endtask

    task automatic test_div_zero();
        wb_rdy = 1'b1;
        drive_op(SDIV, 64'd9, 64'd0, 5'd3);
        settle();
        tick();
        in_vld = 1'b0;
        settle();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL divz_out_vld got %b want 1", out_vld); end
        checks++; if (out_data !== {DATA_W{1'b1}}) begin errors++; $display("FAIL divz_data got %h want all ones", out_data); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL divz_err got %b want 1", out_err); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL divz_in_rdy got %b want 1", in_rdy); end
        tick();
        settle();
    endtask

    task automatic test_hold();
        wb_rdy = 1'b0;
        drive_op(SMUL, 64'd3, 64'd5, 5'd7);
        settle();
        tick();
        drive_op(SADD, 64'hDEAD, 64'hBEEF, 5'd30);
        settle();
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL hold_vld[%0d] got %b want 1", i, out_vld); end
            checks++; if (out_data !== 64'd15) begin errors++; $display("FAIL hold_data[%0d] got %0d want 15", i, out_data); end
            checks++; if (out_vreg !== 5'd7) begin errors++; $display("FAIL hold_vreg[%0d] got %0d want 7", i, out_vreg); end
            checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL hold_in_rdy[%0d] got %b want 0", i, in_rdy); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy[%0d] got %b want 1", i, busy); end
            tick();
            settle();
        end
        wb_rdy = 1'b1;
        drive_op(SSUB, 64'd10, 64'd3, 5'd2);
        settle();
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL hold_release_in_rdy got %b want 1", in_rdy); end
        tick();
        in_vld = 1'b0;
        settle();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL sub_vld got %b want 1", out_vld); end
        checks++; if (out_data !== 64'd7) begin errors++; $display("FAIL sub_data got %0d want 7", out_data); end
        checks++; if (out_vreg !== 5'd2) begin errors++; $display("FAIL sub_vreg got %0d want 2", out_vreg); end
        tick();
        settle();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_data [8];
        logic [VREG_W-1:0] exp_tag [8];
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        wb_rdy = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                drive_op(SADD, a, b, VREG_W'(i + 8));
                exp_data[i] = a + b;
                exp_tag[i]  = VREG_W'(i + 8);
            end else begin
                in_vld = 1'b0;
            end
            settle();
            if (i < 8) begin
                checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_in_rdy[%0d] got %b want 1", i, in_rdy); end
            end
            if (i > 0) begin
                checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld[%0d] got %b want 1", i - 1, out_vld); end
                checks++; if (out_data !== exp_data[i-1]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i - 1, out_data, exp_data[i-1]); end
                checks++; if (out_vreg !== exp_tag[i-1]) begin errors++; $display("FAIL b2b_vreg[%0d] got %0d want %0d", i - 1, out_vreg, exp_tag[i-1]); end
            end
            tick();
        end
        settle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_vld); end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        wb_rdy = 1'b1;
        drive_op(SDIV, 64'h0123_4567_89AB_CDEF, 64'd3, 5'd4);
        settle();
        tick();
        in_vld = 1'b0;
        settle();
        for (int i = 1; i < 30; i++) begin
            tick();
            settle();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rstdiv_vld got %b want 0", out_vld); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rstdiv_in_rdy got %b want 1", in_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstdiv_busy got %b want 0", busy); end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_vld === 1'b1) seen++;
            tick();
            settle();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstdiv_stale_result got %0d valid cycles want 0", seen); end
        wb_rdy = 1'b0;
        drive_op(SADD, 64'd1, 64'd2, 5'd6);
        settle();
        tick();
        in_vld = 1'b0;
        reset  = 1'b1;
        settle();
        tick();
        reset  = 1'b0;
        wb_rdy = 1'b1;
        settle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rsthold_vld got %b want 0", out_vld); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rsthold_in_rdy got %b want 1", in_rdy); end
    endtask

    task automatic test_random();
        int                wait_cnt;
        bit                pend;
        logic [DATA_W:0]   pend_val;
        logic [VREG_W-1:0] pend_tag;
        bit                model_rdy;
        bit                exp_vld;
        function_opcode_t  op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        wait_cnt = 0;
        pend     = 0;
        pend_val = '0;
        pend_tag = '0;
        for (int c = 0; c < 600; c++) begin
            op = function_opcode_t'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = 64'($urandom_range(1, 1000));
                default: b = {$urandom, $urandom};
            endcase
            drive_op(op, a, b, VREG_W'($urandom_range(0, NUM_VREG - 1)));
            in_vld = ($urandom_range(0, 1) == 1);
            wb_rdy = ($urandom_range(0, 3) != 0);
            settle();
            model_rdy = (wait_cnt == 0) && (!pend || wb_rdy);
            exp_vld   = pend && (wait_cnt == 0);
            checks++; if (in_rdy !== model_rdy) begin errors++; $display("FAIL rand_in_rdy[%0d] got %b want %b", c, in_rdy, model_rdy); end
            checks++; if (out_vld !== exp_vld) begin errors++; $display("FAIL rand_out_vld[%0d] got %b want %b", c, out_vld, exp_vld); end
            if (exp_vld) begin
                checks++; if ({out_err, out_data} !== pend_val) begin errors++; $display("FAIL rand_result[%0d] got err=%b data=%h want err=%b data=%h", c, out_err, out_data, pend_val[DATA_W], pend_val[DATA_W-1:0]); end
                checks++; if (out_vreg !== pend_tag) begin errors++; $display("FAIL rand_vreg[%0d] got %0d want %0d", c, out_vreg, pend_tag); end
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
            end else begin
                if (pend && wb_rdy) pend = 0;
                if (in_vld && model_rdy) begin
                    pend     = 1;
                    pend_val = ref_op(op, a, b);
                    pend_tag = in_vreg;
                    wait_cnt = (op == SDIV && b != 0) ? DATA_W : 0;
                end
            end
            tick();
        end
        in_vld = 1'b0;
        wb_rdy = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_div();
        test_div_zero();
        test_hold();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
